error_deser: RTL and testbench

ERROR_DESER -- requirements
Module: error_deser

---
 rtl/error_deser_pkg.sv | 18 +
 rtl/err_shift_lane.sv | 39 +++
 rtl/error_deser.sv | 129 ++++++++++++
 tb/tb_error_deser.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/error_deser_pkg.sv
// Shared definitions for the error-word deserializer and its matching serializer.
package error_deser_pkg;

   // Default frame length in bits per lane.
   localparam int FL_DEFAULT = 104;

   // Frame assembly state.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } deser_state_t;

   // Bit-counter width large enough to hold 0..fl.
   function automatic int cnt_width(input int fl);
      return $clog2(fl + 1);
   endfunction

endpackage

// File: rtl/err_shift_lane.sv
// One serial lane: LSB-first shift register.
// New bits enter at the MSB and the contents move right, so after FL samples
// the first bit received sits in bit 0.
// 'word' presents the register as it will be after the current edge.
// The controller can then capture a completed frame on the same edge that
// samples its final bit.
module err_shift_lane
   import error_deser_pkg::*;
#(
   parameter int FL = FL_DEFAULT
) (
   input  logic          Clock,
   input  logic          nReset,
   input  logic          shift_en,
   input  logic          bit_in,
   output logic [FL-1:0] word
);

   logic [FL-1:0] shreg;

   // Next-state view of the shift register.
   always_comb begin
      word = shreg;
      if (shift_en) begin
         word = {bit_in, shreg[FL-1:1]};
      end
   end

   // A full frame shifts all FL positions, so leftovers from a truncated
   // frame never reach a completed word and need no explicit clear.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         shreg <= '0;
      end else begin
         shreg <= word;
      end
   end

endmodule

// File: rtl/error_deser.sv
// Two-lane serial-to-parallel error-word deserializer.
// The serial side is never stalled.
// A frame that completes while the previous word is still unaccepted is
// dropped, and the drop is flagged in the sticky Overrun bit.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | between frames; the next KeepShift bit starts a new frame
//  SHIFT | mid-frame; count holds the number of bits already sampled
module error_deser
   import error_deser_pkg::*;
#(
   parameter int FL = FL_DEFAULT
) (
   input  logic          Clock,
   input  logic          nReset,
   input  logic          KeepShift,
   input  logic          bitin1,
   input  logic          bitin2,
   input  logic          Ready,
   input  logic          Clr_Status,
   output logic [FL-1:0] b1_error1,
   output logic [FL-1:0] b1_error2,
   output logic          Valid_Data,
   output logic          Frame_Err,
   output logic          Overrun
);

   localparam int CW = cnt_width(FL);
   localparam logic [CW-1:0] CNT_LAST = CW'(FL - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   deser_state_t  state;
   logic [CW-1:0] count;
   logic [FL-1:0] lane1_word;
   logic [FL-1:0] lane2_word;
   logic          frame_done;
   logic          word_accept;
   logic          ovr_set;

   // Both lanes shift on every strobe, whatever the state.
   // The serial input is never held off.
   err_shift_lane #(.FL(FL)) u_lane1 (
      .Clock    (Clock),
      .nReset   (nReset),
      .shift_en (KeepShift),
      .bit_in   (bitin1),
      .word     (lane1_word)
   );

   err_shift_lane #(.FL(FL)) u_lane2 (
      .Clock    (Clock),
      .nReset   (nReset),
      .shift_en (KeepShift),
      .bit_in   (bitin2),
      .word     (lane2_word)
   );

   // Decode the final-bit cycle and the output handshake outcome.
   always_comb begin
      frame_done  = (state == SHIFT) && KeepShift && (count == CNT_LAST);
      word_accept = !Valid_Data || Ready;
      ovr_set     = frame_done && !word_accept;
   end

   // Frame FSM, bit counter, output word register and status flags.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state      <= IDLE;
         count      <= '0;
         b1_error1  <= '0;
         b1_error2  <= '0;
         Valid_Data <= 1'b0;
         Frame_Err  <= 1'b0;
         Overrun    <= 1'b0;
      end else begin
         Frame_Err <= 1'b0;

         case (state)
            IDLE: begin
               if (KeepShift) begin
                  count <= CNT_ONE;
                  state <= SHIFT;
               end else begin
                  count <= '0;
               end
            end
            SHIFT: begin
               if (KeepShift) begin
                  if (count == CNT_LAST) begin
                     count <= '0;
                     state <= IDLE;
                  end else begin
                     count <= count + CNT_ONE;
                  end
               end else begin
                  count     <= '0;
                  Frame_Err <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               count <= '0;
               state <= IDLE;
            end
         endcase

         // A completed frame replaces the held word only if it is free or
         // leaving this cycle. Otherwise the old word stays put.
         if (frame_done) begin
            if (word_accept) begin
               b1_error1  <= lane1_word;
               b1_error2  <= lane2_word;
               Valid_Data <= 1'b1;
            end
         end else if (Valid_Data && Ready) begin
            Valid_Data <= 1'b0;
         end

         // A drop in the same cycle as a clear wins, so no event is lost.
         if (ovr_set) begin
            Overrun <= 1'b1;
         end else if (Clr_Status) begin
            Overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_error_deser.sv
// Directed and randomized-loopback bench for error_deser at FL=104.
module tb_error_deser;
   import error_deser_pkg::*;

   localparam int FL = FL_DEFAULT;

   logic          Clock = 1'b0;
   logic          nReset = 1'b0;
   logic          KeepShift = 1'b0;
   logic          bitin1 = 1'b0;
   logic          bitin2 = 1'b0;
   logic          Ready = 1'b0;
   logic          Clr_Status = 1'b0;
   logic [FL-1:0] b1_error1;
   logic [FL-1:0] b1_error2;
   logic          Valid_Data;
   logic          Frame_Err;
   logic          Overrun;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural expectation of the output side, advanced once per edge.
   logic          m_valid = 1'b0;
   logic          m_ovr = 1'b0;
   logic [FL-1:0] m_w1 = '0;
   logic [FL-1:0] m_w2 = '0;
   logic [FL-1:0] f1 = '0;
   logic [FL-1:0] f2 = '0;

   logic [FL-1:0] ones;
   logic [FL-1:0] wa, wb, wc, wd, we;

   error_deser #(.FL(FL)) dut (
      .Clock      (Clock),
      .nReset     (nReset),
      .KeepShift  (KeepShift),
      .bitin1     (bitin1),
      .bitin2     (bitin2),
      .Ready      (Ready),
      .Clr_Status (Clr_Status),
      .b1_error1  (b1_error1),
      .b1_error2  (b1_error2),
      .Valid_Data (Valid_Data),
      .Frame_Err  (Frame_Err),
      .Overrun    (Overrun)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [FL-1:0] rand_word();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[FL-1:0];
   endfunction

   // Drive one cycle (called at posedge+1), advance the model at the edge,
   // and return at posedge+1.
   task automatic step(input logic ks, input logic b1, input logic b2,
                       input logic rdy, input logic clr, input logic last);
      logic set;
      KeepShift  = ks;
      bitin1     = b1;
      bitin2     = b2;
      Ready      = rdy;
      Clr_Status = clr;
      @(posedge Clock);
      set = 1'b0;
      if (last && ks) begin
         if (!m_valid || rdy) begin
            m_valid = 1'b1;
            m_w1    = f1;
            m_w2    = f2;
         end else begin
            set = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
      if (set) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      #1;
   endtask

   // rdy_mode: 0 = Ready low, 1 = Ready high, 2 = random; the final bit uses rdy_last unless random.
   task automatic send_frame(input logic [FL-1:0] w1, input logic [FL-1:0] w2, input int nbits,
                             input int rdy_mode, input logic rdy_last, input logic clr_last);
      logic r;
      f1 = w1;
      f2 = w2;
      for (int i = 0; i < nbits; i++) begin
         case (rdy_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            default: r = 1'($urandom_range(0, 1));
         endcase
         if (i == FL - 1 && rdy_mode != 2) r = rdy_last;
         step(1'b1, w1[i], w2[i], r, (i == FL - 1) ? clr_last : 1'b0, i == FL - 1);
      end
      KeepShift = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, "_valid"}, Valid_Data, m_valid);
      check({tag, "_w1"}, b1_error1, m_w1);
      check({tag, "_w2"}, b1_error2, m_w2);
      check({tag, "_ovr"}, Overrun, m_ovr);
   endtask

   initial begin
      ones = '1;
      wa = 104'hA1A2_A3A4_A5A6_A7A8_A9AA_ABAC_AD;
      wb = 104'h0B1B_2B3B_4B5B_6B7B_8B9B_ABBB_CB;
      wc = 104'hC0FF_EE00_1234_5678_9ABC_DEF0_11;
      wd = 104'hD00D_F00D_CAFE_BABE_DEAD_BEEF_42;
      we = 104'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A;

      // Reset state
      #2;
      check("rst_valid", Valid_Data, 1'b0);
      check("rst_ferr", Frame_Err, 1'b0);
      check("rst_ovr", Overrun, 1'b0);
      check("rst_w1", b1_error1, 104'h0);
      check("rst_w2", b1_error2, 104'h0);
      @(posedge Clock);
      #1;
      nReset = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Full frame: lane1 = 1, lane2 = all ones
      send_frame(104'h1, ones, FL, 0, 1'b0, 1'b0);
      check("f1_valid", Valid_Data, 1'b1);
      check("f1_w1", b1_error1, 104'h1);
      check("f1_w2", b1_error2, ones);
      check("f1_ferr", Frame_Err, 1'b0);
      check("f1_ovr", Overrun, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("acc_valid", Valid_Data, 1'b0);
      check("acc_w1_hold", b1_error1, 104'h1);

      // Truncated frame after 50 bits
      send_frame(wa, wb, 50, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("trunc_ferr", Frame_Err, 1'b1);
      check("trunc_valid", Valid_Data, 1'b0);
      check("trunc_w1_hold", b1_error1, 104'h1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("trunc_ferr_pulse", Frame_Err, 1'b0);
      send_frame(wc, wd, FL, 0, 1'b0, 1'b0);
      check("after_trunc_valid", Valid_Data, 1'b1);
      check("after_trunc_w1", b1_error1, wc);
      check("after_trunc_w2", b1_error2, wd);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Overrun with Ready held low, back-to-back frames
      send_frame(wa, wb, FL, 0, 1'b0, 1'b0);
      send_frame(wc, wd, FL, 0, 1'b0, 1'b0);
      check("ovr_valid", Valid_Data, 1'b1);
      check("ovr_w1_kept", b1_error1, wa);
      check("ovr_w2_kept", b1_error2, wb);
      check("ovr_set", Overrun, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("ovr_clr", Overrun, 1'b0);
      send_frame(wd, wc, FL, 0, 1'b0, 1'b1);
      check("ovr_set_wins", Overrun, 1'b1);
      check("ovr_set_wins_w1", b1_error1, wa);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("ovr_clr2", Overrun, 1'b0);

      // Ready in the completion cycle of frame 2: seamless switch
      send_frame(wd, we, FL, 0, 1'b1, 1'b0);
      check("swap_valid", Valid_Data, 1'b1);
      check("swap_w1", b1_error1, wd);
      check("swap_w2", b1_error2, we);
      check("swap_ovr", Overrun, 1'b0);

      // Reset at bit 60 while a word is held
      send_frame(wa, wb, 60, 0, 1'b0, 1'b0);
      nReset = 1'b0;
      #1;
      check("mid_rst_valid", Valid_Data, 1'b0);
      check("mid_rst_w1", b1_error1, 104'h0);
      check("mid_rst_w2", b1_error2, 104'h0);
      check("mid_rst_ferr", Frame_Err, 1'b0);
      check("mid_rst_ovr", Overrun, 1'b0);
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_w1    = '0;
      m_w2    = '0;
      @(posedge Clock);
      #1;
      nReset = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(104'hA5, we, FL, 0, 1'b0, 1'b0);
      check("post_rst_valid", Valid_Data, 1'b1);
      check("post_rst_w1", b1_error1, 104'hA5);
      check("post_rst_w2", b1_error2, we);
      check("post_rst_ferr", Frame_Err, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      m_valid = 1'b0;
      m_w1    = 104'hA5;
      m_w2    = we;

      // Loopback, Ready always high, back-to-back frames
      for (int k = 0; k < 20; k++) begin
         logic [FL-1:0] r1, r2;
         r1 = rand_word();
         r2 = rand_word();
         send_frame(r1, r2, FL, 1, 1'b1, 1'b0);
         check("lb_valid", Valid_Data, 1'b1);
         check("lb_w1", b1_error1, r1);
         check("lb_w2", b1_error2, r2);
         check("lb_ovr", Overrun, 1'b0);
      end

      // Loopback, random Ready and random gaps
      for (int k = 0; k < 30; k++) begin
         int gap;
         send_frame(rand_word(), rand_word(), FL, 2, 1'b0, 1'b0);
         check_model("rnd_end");
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         end
         check_model("rnd_gap");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
